// File: rtl/ecpu_pkg.sv
// Shared types for the writeback / register-file write-port path.
package ecpu_pkg;

    localparam int ECPU_XLEN    = 32;
    localparam int ECPU_REG_AW  = 5;

    // One buffered long-latency result (also used as a write record).
    typedef struct packed {
        logic                   valid;
        logic [ECPU_REG_AW-1:0] rd_addr;
        logic [ECPU_XLEN-1:0]   data;
    } wb_entry_t;

    // Arbiter FSM: normal cycle-level arbitration, or a one-cycle forced drain.
    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_DRAIN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small result buffer for long-latency writes. Each slot carries a valid bit
// that can be cleared by rd address (WAW kill) while the slot stays occupied
// until it reaches the head and is popped.
module wb_result_fifo
    import ecpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = ECPU_REG_AW,
    parameter int DW    = ECPU_XLEN,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    input  logic          kill_i,
    input  logic [AW-1:0] kill_addr_i,
    output logic          full_o,
    output logic          head_occ_o,
    output logic          head_valid_o,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o,
    output logic [CW-1:0] valid_count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]   wr_ptr_reg;
    logic [PW:0]   rd_ptr_reg;
    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic          valid_reg [DEPTH];

    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          empty;
    logic          do_push;
    logic          do_pop;
    logic          push_killed;

    assign wr_idx      = wr_ptr_reg[PW-1:0];
    assign rd_idx      = rd_ptr_reg[PW-1:0];
    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full_o      = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) && (wr_idx == rd_idx);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty;
    // An entry enqueued on the same edge as a pipeline write to the same rd is older.
    assign push_killed = kill_i && (push_addr_i == kill_addr_i);

    assign head_occ_o   = !empty;
    assign head_valid_o = !empty && valid_reg[rd_idx];
    assign head_addr_o  = addr_mem[rd_idx];
    assign head_data_o  = data_mem[rd_idx];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Payload storage, written only on enqueue.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            addr_mem[wr_idx] <= push_addr_i;
            data_mem[wr_idx] <= push_data_i;
        end
    end

    // Per-slot valid bits: set on enqueue, cleared on pop or by a matching kill.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_reg[gi] <= 1'b0;
                end else if (do_push && (wr_idx == PW'(gi))) begin
                    valid_reg[gi] <= !push_killed;
                end else if (do_pop && (rd_idx == PW'(gi))) begin
                    valid_reg[gi] <= 1'b0;
                end else if (kill_i && valid_reg[gi] && (addr_mem[gi] == kill_addr_i)) begin
                    valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Occupancy as seen by software: only live (not killed) entries.
    always_comb begin
        valid_count_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_count_o = valid_count_o + CW'(valid_reg[i]);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// writeback stage and buffered long-latency results, with a one-cycle forced
// drain when buffered results are starved.
module wb_port_arbiter
    import ecpu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            pipe_we_i,
    input  logic [REG_ADDR_WIDTH-1:0]       pipe_rd_addr_i,
    input  logic [XLEN-1:0]                 pipe_rd_data_i,
    input  logic                            lu_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]       lu_rd_addr_i,
    input  logic [XLEN-1:0]                 lu_rd_data_i,
    output logic                            lu_ready_o,
    output logic                            rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0]       rf_rd_addr_o,
    output logic [XLEN-1:0]                 rf_rd_data_o,
    output logic                            stall_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] pending_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e                state_reg, state_next;
    logic [SW-1:0]             starve_reg, starve_next;
    logic                      rf_we_reg;
    logic [REG_ADDR_WIDTH-1:0] rf_addr_reg;
    logic [XLEN-1:0]           rf_data_reg;
    logic                      stall_reg;
    logic                      ready_en_reg;

    logic                      fifo_full;
    logic                      head_occ;
    logic                      head_valid;
    logic [REG_ADDR_WIDTH-1:0] head_addr;
    logic [XLEN-1:0]           head_data;
    logic [CW-1:0]             valid_count;

    logic                      pipe_req;
    logic                      grant_pipe;
    logic                      grant_head;
    logic                      fifo_pop;
    logic                      fifo_push;

    // x0 writes are architecturally void: not a port request, not stored.
    assign pipe_req   = pipe_we_i && (pipe_rd_addr_i != '0);
    // ready_en_reg keeps the producer blocked until the first edge after reset.
    assign lu_ready_o = ready_en_reg && !fifo_full;
    assign fifo_push  = lu_valid_i && lu_ready_o && (lu_rd_addr_i != '0);

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (REG_ADDR_WIDTH),
        .DW    (XLEN),
        .CW    (CW)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (fifo_push),
        .push_addr_i   (lu_rd_addr_i),
        .push_data_i   (lu_rd_data_i),
        .pop_i         (fifo_pop),
        .kill_i        (grant_pipe),
        .kill_addr_i   (pipe_rd_addr_i),
        .full_o        (fifo_full),
        .head_occ_o    (head_occ),
        .head_valid_o  (head_valid),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .valid_count_o (valid_count)
    );

    // Grant selection: pipeline first in NORMAL, head unconditionally in DRAIN.
    // A killed head is popped without using the port.
    always_comb begin
        grant_pipe = 1'b0;
        grant_head = 1'b0;
        if (state_reg == ARB_DRAIN) begin
            grant_head = head_valid;
        end else if (pipe_req) begin
            grant_pipe = 1'b1;
        end else begin
            grant_head = head_valid;
        end
        fifo_pop = grant_head || (head_occ && !head_valid);
    end

    // Starvation counter and next-state: drain once the counter reaches the limit.
    always_comb begin
        starve_next = starve_reg;
        state_next  = ARB_NORMAL;
        if (state_reg == ARB_DRAIN) begin
            starve_next = '0;
        end else begin
            if (grant_head || (valid_count == '0)) begin
                starve_next = '0;
            end else if (head_valid && (starve_reg < STARVE_MAX)) begin
                starve_next = starve_reg + 1'b1;
            end
            if (starve_next == STARVE_MAX) begin
                state_next = ARB_DRAIN;
            end
        end
    end

    // FSM state and all registered outputs toward the register file.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ARB_NORMAL;
            starve_reg   <= '0;
            rf_we_reg    <= 1'b0;
            rf_addr_reg  <= '0;
            rf_data_reg  <= '0;
            stall_reg    <= 1'b0;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            starve_reg   <= starve_next;
            stall_reg    <= (state_next == ARB_DRAIN);
            ready_en_reg <= 1'b1;
            rf_we_reg    <= grant_pipe || grant_head;
            if (grant_pipe) begin
                rf_addr_reg <= pipe_rd_addr_i;
                rf_data_reg <= pipe_rd_data_i;
            end else if (grant_head) begin
                rf_addr_reg <= head_addr;
                rf_data_reg <= head_data;
            end
        end
    end

    assign rf_we_o      = rf_we_reg;
    assign rf_rd_addr_o = rf_addr_reg;
    assign rf_rd_data_o = rf_data_reg;
    assign stall_o      = stall_reg;
    assign pending_o    = valid_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes are queued
// as stimulus is driven and checked in order by a write monitor.
module tb_wb_port_arbiter;
    import ecpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        pipe_we_i;
    logic [4:0]  pipe_rd_addr_i;
    logic [31:0] pipe_rd_data_i;
    logic        lu_valid_i;
    logic [4:0]  lu_rd_addr_i;
    logic [31:0] lu_rd_data_i;
    logic        lu_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_rd_addr_o;
    logic [31:0] rf_rd_data_o;
    logic        stall_o;
    logic [1:0]  pending_o;

    int checks   = 0;
    int failures = 0;
    wb_entry_t exp_q[$];

    wb_port_arbiter #(
        .XLEN           (32),
        .REG_ADDR_WIDTH (5),
        .FIFO_DEPTH     (2),
        .STARVE_LIMIT   (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pipe_we_i      (pipe_we_i),
        .pipe_rd_addr_i (pipe_rd_addr_i),
        .pipe_rd_data_i (pipe_rd_data_i),
        .lu_valid_i     (lu_valid_i),
        .lu_rd_addr_i   (lu_rd_addr_i),
        .lu_rd_data_i   (lu_rd_data_i),
        .lu_ready_o     (lu_ready_o),
        .rf_we_o        (rf_we_o),
        .rf_rd_addr_o   (rf_rd_addr_o),
        .rf_rd_data_o   (rf_rd_data_o),
        .stall_o        (stall_o),
        .pending_o      (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        wb_entry_t e;
        e.valid   = 1'b1;
        e.rd_addr = rd;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        pipe_we_i      = pwe;
        pipe_rd_addr_i = prd;
        pipe_rd_data_i = pd;
        lu_valid_i     = lv;
        lu_rd_addr_i   = lrd;
        lu_rd_data_i   = ld;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Write monitor: every rf write must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && rf_we_o === 1'b1) begin
            wb_entry_t e;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL rf_unexpected_write observed=x%0d:%0h expected=no_write",
                       rf_rd_addr_o, rf_rd_data_o);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rf_addr", 32'(rf_rd_addr_o), 32'(e.rd_addr));
                chk("rf_data", rf_rd_data_o, e.data);
                $display("rf write x%0d = %08h", rf_rd_addr_o, rf_rd_data_o);
            end
        end
    end

    initial begin
        // 1. reset with a producer already asserting valid
        rst_ni = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h5555);
        cyc();
        cyc();
        chk("rst_lu_ready", 32'(lu_ready_o), 32'd0);
        chk("rst_rf_we", 32'(rf_we_o), 32'd0);
        chk("rst_rf_addr", 32'(rf_rd_addr_o), 32'd0);
        chk("rst_rf_data", rf_rd_data_o, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_pending", 32'(pending_o), 32'd0);
        rst_ni = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("rel_ready_same_cycle", 32'(lu_ready_o), 32'd0);
        cyc();
        chk("rel_ready_next_cycle", 32'(lu_ready_o), 32'd1);

        // 2. idle pipe, single long-latency result
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        expect_wr(5'd5, 32'hDEADBEEF);
        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("t2_pending_1", 32'(pending_o), 32'd1);
        cyc();
        chk("t2_pending_0", 32'(pending_o), 32'd0);
        cyc();

        // 3. pipe busy on x3: four denied cycles, one-cycle drain, pipe resumes
        drive(1'b1, 5'd3, 32'h100, 1'b1, 5'd7, 32'h11);
        expect_wr(5'd3, 32'h100);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("t3_no_stall", 32'(stall_o), 32'd0);
            drive(1'b1, 5'd3, 32'h100 + 32'(k), 1'b0, 5'd0, 32'h0);
            expect_wr(5'd3, 32'h100 + 32'(k));
        end
        cyc();
        chk("t3_stall", 32'(stall_o), 32'd1);
        chk("t3_pending_before_drain", 32'(pending_o), 32'd1);
        drive(1'b1, 5'd3, 32'h105, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd7, 32'h11);
        cyc();
        chk("t3_stall_one_cycle", 32'(stall_o), 32'd0);
        chk("t3_pending_after_drain", 32'(pending_o), 32'd0);
        drive(1'b1, 5'd3, 32'h105, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd3, 32'h105);
        cyc();
        drive(1'b1, 5'd3, 32'h106, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd3, 32'h106);
        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc();

        // 4. WAW kill: buffered x9 superseded by a younger pipeline write
        drive(1'b1, 5'd4, 32'h200, 1'b1, 5'd9, 32'hAA);
        expect_wr(5'd4, 32'h200);
        cyc();
        chk("t4_pending_1", 32'(pending_o), 32'd1);
        drive(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd9, 32'hBB);
        cyc();
        chk("t4_pending_killed", 32'(pending_o), 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc();
        cyc();
        chk("t4_ready_after_skip", 32'(lu_ready_o), 32'd1);

        // 5. fill the FIFO while the pipe is busy; third result must wait
        drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd10, 32'hA1);
        expect_wr(5'd3, 32'h300);
        cyc();
        drive(1'b1, 5'd3, 32'h301, 1'b1, 5'd11, 32'hA2);
        expect_wr(5'd3, 32'h301);
        cyc();
        chk("t5_full_not_ready", 32'(lu_ready_o), 32'd0);
        chk("t5_pending_2", 32'(pending_o), 32'd2);
        for (int k = 2; k <= 4; k++) begin
            drive(1'b1, 5'd3, 32'h300 + 32'(k), 1'b1, 5'd12, 32'hA3);
            expect_wr(5'd3, 32'h300 + 32'(k));
            cyc();
        end
        chk("t5_stall", 32'(stall_o), 32'd1);
        chk("t5_still_full", 32'(lu_ready_o), 32'd0);
        drive(1'b1, 5'd3, 32'h305, 1'b1, 5'd12, 32'hA3);
        expect_wr(5'd10, 32'hA1);
        cyc();
        chk("t5_ready_after_pop", 32'(lu_ready_o), 32'd1);
        drive(1'b1, 5'd3, 32'h305, 1'b1, 5'd12, 32'hA3);
        expect_wr(5'd3, 32'h305);
        cyc();
        chk("t5_pending_after_third", 32'(pending_o), 32'd2);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd11, 32'hA2);
        cyc();
        expect_wr(5'd12, 32'hA3);
        cyc();
        cyc();
        chk("t5_pending_drained", 32'(pending_o), 32'd0);

        // 6. x0 results and x0 pipeline writes never reach the register file
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
        chk("t6_x0_ready", 32'(lu_ready_o), 32'd1);
        cyc();
        drive(1'b1, 5'd0, 32'h5678, 1'b0, 5'd0, 32'h0);
        chk("t6_x0_pending", 32'(pending_o), 32'd0);
        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cyc();
        cyc();
        chk("t6_x0_pending_after", 32'(pending_o), 32'd0);
        chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
